// File: rtl/truth_table_scanner.sv
// Truth-table scanner: steps {p,q,r,s} through every minterm, samples the block
// under test after a settle window and compares the captured table to EXPECT.
module truth_table_scanner #(
  parameter int                   N_VARS = 4,
  parameter logic [2**N_VARS-1:0] EXPECT = 16'h4644,
  parameter int                   SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   f_in,
  output logic [N_VARS-1:0]      vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [2**N_VARS-1:0]   signature,
  output logic [N_VARS:0]        mismatch_cnt,
  output logic [N_VARS-1:0]      mismatch_idx
);

  localparam logic [7:0]        SETTLE_C = 8'(SETTLE);
  localparam logic [N_VARS-1:0] LAST_IDX = '1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                 state_q;
  logic [N_VARS-1:0]      idx_q;
  logic [7:0]             waitCnt_q;
  logic                   firstFail_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pass_q;
  logic [2**N_VARS-1:0]   signature_q;
  logic [N_VARS:0]        mismatchCnt_q;
  logic [N_VARS-1:0]      mismatchIdx_q;

  logic                   sampleEdge_d;
  logic                   miss_d;
  logic [N_VARS:0]        mismatchCnt_d;

  // The sample edge is the last edge of each vector's SETTLE+1 cycle window.
  always_comb begin
    sampleEdge_d  = (state_q == SCAN) && (waitCnt_q == SETTLE_C);
    miss_d        = (f_in != EXPECT[idx_q]);
    mismatchCnt_d = mismatchCnt_q + {{N_VARS{1'b0}}, miss_d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      waitCnt_q     <= '0;
      firstFail_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      signature_q   <= '0;
      mismatchCnt_q <= '0;
      mismatchIdx_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= SCAN;
            idx_q         <= '0;
            waitCnt_q     <= '0;
            busy_q        <= 1'b1;
            firstFail_q   <= 1'b0;
            pass_q        <= 1'b0;
            signature_q   <= '0;
            mismatchCnt_q <= '0;
            mismatchIdx_q <= '0;
          end
        end
        SCAN: begin
          if (!sampleEdge_d) begin
            waitCnt_q <= waitCnt_q + 8'd1;
          end else begin
            signature_q[idx_q] <= f_in;
            mismatchCnt_q      <= mismatchCnt_d;
            waitCnt_q          <= '0;
            if (miss_d && !firstFail_q) begin
              mismatchIdx_q <= idx_q;
              firstFail_q   <= 1'b1;
            end
            // Pass is judged on the count including the final sample.
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (mismatchCnt_d == '0);
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec_out      = busy_q ? idx_q : '0;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign signature    = signature_q;
  assign mismatch_cnt = mismatchCnt_q;
  assign mismatch_idx = mismatchIdx_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: SETTLE=1 instance for most scenarios,
// SETTLE=0 instance for back-to-back scans with start held high.
module tb_truth_table_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic        fIn;
  logic [3:0]  vecOut;
  logic        busy, done, pass;
  logic [15:0] signature;
  logic [4:0]  mismatchCnt;
  logic [3:0]  mismatchIdx;

  logic        start0 = 1'b0;
  logic        fIn0;
  logic [3:0]  vecOut0;
  logic        busy0, done0, pass0;
  logic [15:0] signature0;
  logic [4:0]  mismatchCnt0;
  logic [3:0]  mismatchIdx0;

  int mode = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  function automatic logic goldenF(input logic [3:0] v);
    return (v[3] & ~v[2] & ~v[1] & v[0]) | (v[1] & ~v[0]);
  endfunction

  // mode 0: golden block, 1: output stuck at 0, 2: minterm 9 inverted
  assign fIn  = (mode == 1) ? 1'b0 : (goldenF(vecOut) ^ (mode == 2 && vecOut == 4'd9));
  assign fIn0 = goldenF(vecOut0);

  truth_table_scanner #(.N_VARS(4), .EXPECT(16'h4644), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(fIn), .vec_out(vecOut),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .mismatch_cnt(mismatchCnt), .mismatch_idx(mismatchIdx)
  );

  truth_table_scanner #(.N_VARS(4), .EXPECT(16'h4644), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .f_in(fIn0), .vec_out(vecOut0),
    .busy(busy0), .done(done0), .pass(pass0), .signature(signature0),
    .mismatch_cnt(mismatchCnt0), .mismatch_idx(mismatchIdx0)
  );

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the start edge; records done timing and vec_out stepping.
  task automatic measureScan(input int hold, input int rA, input int rB,
                             output int doneAt, output int doneCount, output bit vecOk);
    doneAt = -1;
    doneCount = 0;
    vecOk = (vecOut === 4'd0);
    for (int j = 1; j <= 16 * hold + 8; j++) begin
      @(posedge clk); #1;
      if (j < 16 * hold && vecOut !== 4'(j / hold)) vecOk = 1'b0;
      if (done === 1'b1) begin
        doneCount++;
        if (doneAt < 0) doneAt = j;
      end
      start = (j == rA || j == rB);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    @(posedge clk); #1;
    total++; if ({vecOut, busy, done, pass, signature, mismatchCnt, mismatchIdx} !== '0) begin
      bad++; $display("[TB] FAIL reset_outputs got vec=%h busy=%b done=%b pass=%b sig=%h cnt=%0d idx=%0d want all 0",
                      vecOut, busy, done, pass, signature, mismatchCnt, mismatchIdx); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, done, vecOut} !== 6'b0) begin
      bad++; $display("[TB] FAIL idle_after_reset got busy=%b done=%b vec=%h want 0 0 0", busy, done, vecOut); end
  endtask

  task automatic test_golden();
    int doneAt, doneCount; bit vecOk;
    mode = 0;
    startPulse();
    measureScan(2, -1, -1, doneAt, doneCount, vecOk);
    total++; if (doneAt !== 32) begin bad++; $display("[TB] FAIL golden_done_cycle got %0d want 32", doneAt); end
    total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL golden_done_pulses got %0d want 1", doneCount); end
    total++; if (vecOk !== 1'b1) begin bad++; $display("[TB] FAIL golden_vec_steps got bad stepping want 0..15 every 2 cycles"); end
    total++; if (signature !== 16'h4644) begin bad++; $display("[TB] FAIL golden_sig got %h want 4644", signature); end
    total++; if (pass !== 1'b1) begin bad++; $display("[TB] FAIL golden_pass got %b want 1", pass); end
    total++; if (mismatchCnt !== 5'd0) begin bad++; $display("[TB] FAIL golden_cnt got %0d want 0", mismatchCnt); end
    total++; if (mismatchIdx !== 4'd0) begin bad++; $display("[TB] FAIL golden_idx got %0d want 0", mismatchIdx); end
    repeat (3) @(posedge clk);
    #1;
    total++; if ({busy, pass, signature} !== {1'b0, 1'b1, 16'h4644}) begin
      bad++; $display("[TB] FAIL golden_hold got busy=%b pass=%b sig=%h want 0 1 4644", busy, pass, signature); end
  endtask

  task automatic test_stuck0();
    int doneAt, doneCount; bit vecOk;
    mode = 1;
    startPulse();
    measureScan(2, -1, -1, doneAt, doneCount, vecOk);
    total++; if (doneAt !== 32) begin bad++; $display("[TB] FAIL stuck0_done_cycle got %0d want 32", doneAt); end
    total++; if (signature !== 16'h0000) begin bad++; $display("[TB] FAIL stuck0_sig got %h want 0000", signature); end
    total++; if (mismatchCnt !== 5'd5) begin bad++; $display("[TB] FAIL stuck0_cnt got %0d want 5", mismatchCnt); end
    total++; if (mismatchIdx !== 4'd2) begin bad++; $display("[TB] FAIL stuck0_idx got %0d want 2", mismatchIdx); end
    total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL stuck0_pass got %b want 0", pass); end
  endtask

  task automatic test_invert9();
    int doneAt, doneCount; bit vecOk;
    mode = 2;
    startPulse();
    measureScan(2, -1, -1, doneAt, doneCount, vecOk);
    total++; if (signature !== 16'h4444) begin bad++; $display("[TB] FAIL inv9_sig got %h want 4444", signature); end
    total++; if (mismatchCnt !== 5'd1) begin bad++; $display("[TB] FAIL inv9_cnt got %0d want 1", mismatchCnt); end
    total++; if (mismatchIdx !== 4'd9) begin bad++; $display("[TB] FAIL inv9_idx got %0d want 9", mismatchIdx); end
    total++; if (pass !== 1'b0) begin bad++; $display("[TB] FAIL inv9_pass got %b want 0", pass); end
  endtask

  task automatic test_restart_ignored();
    int doneAt, doneCount; bit vecOk;
    mode = 0;
    startPulse();
    measureScan(2, 5, 20, doneAt, doneCount, vecOk);
    total++; if (doneAt !== 32) begin bad++; $display("[TB] FAIL restart_done_cycle got %0d want 32", doneAt); end
    total++; if (doneCount !== 1) begin bad++; $display("[TB] FAIL restart_done_pulses got %0d want 1", doneCount); end
    total++; if (vecOk !== 1'b1) begin bad++; $display("[TB] FAIL restart_vec_steps got bad stepping want undisturbed"); end
    total++; if ({pass, signature} !== {1'b1, 16'h4644}) begin
      bad++; $display("[TB] FAIL restart_result got pass=%b sig=%h want 1 4644", pass, signature); end
  endtask

  task automatic test_mid_reset();
    int doneAt, doneCount; bit vecOk;
    mode = 0;
    startPulse();
    repeat (14) @(posedge clk);
    #1;
    total++; if ({busy, vecOut} !== {1'b1, 4'd7}) begin
      bad++; $display("[TB] FAIL midrst_pre got busy=%b vec=%0d want 1 7", busy, vecOut); end
    #2 rst_n = 1'b0;
    #1;
    total++; if ({vecOut, busy, done, pass, signature, mismatchCnt, mismatchIdx} !== '0) begin
      bad++; $display("[TB] FAIL midrst_async got vec=%h busy=%b pass=%b sig=%h cnt=%0d idx=%0d want all 0",
                      vecOut, busy, pass, signature, mismatchCnt, mismatchIdx); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    startPulse();
    measureScan(2, -1, -1, doneAt, doneCount, vecOk);
    total++; if (doneAt !== 32) begin bad++; $display("[TB] FAIL midrst_done_cycle got %0d want 32", doneAt); end
    total++; if ({pass, signature, mismatchCnt} !== {1'b1, 16'h4644, 5'd0}) begin
      bad++; $display("[TB] FAIL midrst_result got pass=%b sig=%h cnt=%0d want 1 4644 0", pass, signature, mismatchCnt); end
  endtask

  task automatic test_back_to_back();
    int firstDone = -1, secondDone = -1, doneCount = 0;
    logic [15:0] sig1 = '0, sig2 = '0;
    logic pass1 = 1'b0;
    logic [4:0] cnt1 = '1;
    logic [20:0] snap17 = '1;
    bit vecOk;
    start0 = 1'b1;
    @(posedge clk); #1;
    vecOk = (vecOut0 === 4'd0);
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); #1;
      if (j < 16 && vecOut0 !== 4'(j)) vecOk = 1'b0;
      if (j == 17) snap17 = {busy0, signature0, vecOut0};
      if (done0 === 1'b1) begin
        doneCount++;
        if (firstDone < 0) begin
          firstDone = j; sig1 = signature0; pass1 = pass0; cnt1 = mismatchCnt0;
        end else if (secondDone < 0) begin
          secondDone = j; sig2 = signature0;
        end
      end
    end
    start0 = 1'b0;
    total++; if (vecOk !== 1'b1) begin bad++; $display("[TB] FAIL b2b_vec_steps got bad stepping want +1 per cycle"); end
    total++; if (firstDone !== 16) begin bad++; $display("[TB] FAIL b2b_first_done got %0d want 16", firstDone); end
    total++; if ({pass1, sig1, cnt1} !== {1'b1, 16'h4644, 5'd0}) begin
      bad++; $display("[TB] FAIL b2b_first_result got pass=%b sig=%h cnt=%0d want 1 4644 0", pass1, sig1, cnt1); end
    total++; if (snap17 !== {1'b1, 16'h0000, 4'd0}) begin
      bad++; $display("[TB] FAIL b2b_restart_clear got %h want %h", snap17, {1'b1, 16'h0000, 4'd0}); end
    total++; if (secondDone !== 33) begin bad++; $display("[TB] FAIL b2b_second_done got %0d want 33", secondDone); end
    total++; if (sig2 !== 16'h4644) begin bad++; $display("[TB] FAIL b2b_second_sig got %h want 4644", sig2); end
    total++; if (doneCount !== 2) begin bad++; $display("[TB] FAIL b2b_done_pulses got %0d want 2", doneCount); end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_stuck0();
    test_invert9();
    test_restart_ignored();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
